// File: rtl/module_sp_sync.sv
// module_sp_sync: per-lane serial-to-parallel receiver that hunts for COM, locks byte alignment and emits bytes.
// Optional SP_RESYNC_EN: an off-boundary COM after a boundary COM is treated as a bit slip and realigns.
module module_sp_sync #(
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in_SP,
  output logic [7:0] data_out_SP,
  output logic       valid_out_SP,
  output logic       byte_strobe,
  output logic       active
);
`ifdef SP_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif
  localparam int CW = $clog2(SYNC_COUNT + 1);
  localparam logic [CW-1:0] LOCK_CNT = CW'(SYNC_COUNT - 1);
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [7:0] sr_q, nxt, data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d;
  logic valid_q, valid_d, strobe_q, strobe_d, active_q, active_d, last_com_q, last_com_d;
  logic is_com, boundary;
  assign nxt      = {sr_q[6:0], data_in_SP};
  assign is_com   = nxt == COM_SYM;
  assign boundary = bit_cnt_q == 3'd7;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    com_cnt_d  = com_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    active_d   = active_q;
    last_com_d = last_com_q;
    case (state_q)
      SEARCH: if (is_com) begin
        state_d   = ALIGN;
        bit_cnt_d = 3'd0;
        com_cnt_d = CW'(1);
      end
      ALIGN: if (boundary) begin
        if (!is_com) begin
          state_d   = SEARCH;
          com_cnt_d = '0;
        end else if (com_cnt_q == LOCK_CNT) begin
          state_d    = ACTIVE;
          active_d   = 1'b1;
          last_com_d = 1'b1;
        end else begin
          com_cnt_d = com_cnt_q + CW'(1);
        end
      end
      ACTIVE: if (boundary) begin
        strobe_d   = 1'b1;
        valid_d    = !is_com;
        data_d     = is_com ? data_q : nxt;
        last_com_d = is_com;
      end else if (RESYNC && last_com_q && is_com) begin
        // COM completed off the boundary right after idle: the lane slipped, realign here
        state_d   = ALIGN;
        active_d  = 1'b0;
        valid_d   = 1'b0;
        bit_cnt_d = 3'd0;
        com_cnt_d = CW'(1);
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
      last_com_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= nxt;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
      last_com_q <= last_com_d;
    end
  end
  assign data_out_SP  = data_q;
  assign valid_out_SP = valid_q;
  assign byte_strobe  = strobe_q;
  assign active       = active_q;
endmodule

// File: tb/tb_module_sp_sync.sv
// tb_module_sp_sync: randomized and directed bench for module_sp_sync against a time-indexed behavioural model.
module tb_module_sp_sync;
  localparam logic [7:0] COM = 8'hBC;
  localparam int SC = 4;
`ifdef SP_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0;
  logic [7:0] dout;
  logic vout, stb, act;
  int n_tests = 0, n_fail = 0;

  module_sp_sync dut (
    .clk_32f(clk), .reset_L(rst_n), .data_in_SP(din),
    .data_out_SP(dout), .valid_out_SP(vout), .byte_strobe(stb), .active(act)
  );

  always #5 clk = ~clk;

  // model: mode 0 hunting, 1 counting COMs, 2 locked; bytes end where (t - anchor) is a multiple of 8
  int m_mode, m_t, m_anchor, m_cnt;
  logic [7:0] m_w, m_data;
  logic m_valid, m_stb, m_act, m_lastcom;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_anchor = 0; m_cnt = 0;
    m_w = '0; m_data = '0; m_valid = 0; m_stb = 0; m_act = 0; m_lastcom = 0;
  endtask

  task automatic model_step(input logic b);
    bit on, com;
    m_w = {m_w[6:0], b};
    m_t++;
    m_stb = 0;
    on = ((m_t - m_anchor) % 8) == 0;
    com = m_w == COM;
    if (m_mode == 0) begin
      if (com) begin m_mode = 1; m_anchor = m_t; m_cnt = 1; end
    end else if (m_mode == 1) begin
      if (on) begin
        if (!com) begin m_mode = 0; m_cnt = 0; end
        else if (m_cnt + 1 == SC) begin m_mode = 2; m_act = 1; m_lastcom = 1; end
        else m_cnt++;
      end
    end else if (on) begin
      m_stb = 1;
      if (com) m_valid = 0;
      else begin m_data = m_w; m_valid = 1; end
      m_lastcom = com;
    end else if (RESYNC && m_lastcom && com) begin
      m_mode = 1; m_anchor = m_t; m_cnt = 1; m_act = 0; m_valid = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    model_step(b);
    #1;
  endtask

  task automatic assert_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({act, vout, stb, dout} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: got act=%b valid=%b strobe=%b data=%h, expected all 0", act, vout, stb, dout);
    end
    release_reset();
  endtask

  task automatic test_lock();
    logic [2:0] pre = 3'b101;
    logic pre_act = 1'b1;
    int strobes = 0, valids = 0;
    for (int i = 2; i >= 0; i--) send_bit(pre[i]);
    for (int k = 0; k < 6; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(COM[i]);
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL lock_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
        if (k == 3 && i == 1) pre_act = act;
        if (k >= 4) begin strobes += stb; valids += vout; end
      end
      if (k == 3) begin
        n_tests++;
        if ({pre_act, act} !== 2'b01) begin
          n_fail++;
          $display("FAIL lock_edge: got active before/at 32nd COM bit=%b/%b, expected 0/1", pre_act, act);
        end
      end
    end
    n_tests++;
    if (strobes != 2 || valids != 0) begin
      n_fail++;
      $display("FAIL idle_strobes: got strobes=%0d valid_cycles=%0d, expected 2 and 0", strobes, valids);
    end
  endtask

  task automatic test_data();
    logic [7:0] seq [0:2];
    logic [9:0] want [0:2];
    seq = '{8'hA5, 8'h3C, 8'hBC};
    want = '{{1'b1, 1'b1, 8'hA5}, {1'b1, 1'b1, 8'h3C}, {1'b0, 1'b1, 8'h3C}};
    for (int k = 0; k < 3; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[k][i]);
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL data_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
      end
      n_tests++;
      if ({vout, stb, dout} !== want[k]) begin
        n_fail++;
        $display("FAIL data_byte%0d: got valid=%b strobe=%b data=%h, expected %b %b %h",
                 k, vout, stb, dout, want[k][9], want[k][8], want[k][7:0]);
      end
    end
  endtask

  task automatic test_com_break();
    logic [7:0] seq [0:6];
    seq = '{8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    assert_reset();
    release_reset();
    for (int k = 0; k < 7; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[k][i]);
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL break_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
      end
      n_tests++;
      if (act !== (k == 6)) begin
        n_fail++;
        $display("FAIL break_byte%0d: got active=%b, expected %b", k, act, k == 6);
      end
    end
  endtask

  task automatic test_slip();
    assert_reset();
    release_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 5) send_bit(1'b0);
      for (int i = 7; i >= 0; i--) begin
        send_bit(COM[i]);
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL slip_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
      end
    end
    n_tests++;
    if ({act, vout, dout} !== {1'b1, 1'b1, 8'h5E}) begin
      n_fail++;
      $display("FAIL slip_misalign: got active=%b valid=%b data=%h, expected 1 1 5e", act, vout, dout);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] seq [0:5];
    int strobes = 0;
    seq = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h3C};
    assert_reset();
    release_reset();
    for (int k = 0; k < 6; k++)
      for (int i = 7; i >= (k == 5 ? 5 : 0); i--) send_bit(seq[k][i]);
    n_tests++;
    if ({act, vout, dout} !== {1'b1, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL pre_reset: got active=%b valid=%b data=%h, expected 1 1 a5", act, vout, dout);
    end
    assert_reset();
    n_tests++;
    if ({act, vout, stb, dout} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: got act=%b valid=%b strobe=%b data=%h, expected all 0", act, vout, stb, dout);
    end
    release_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 7; i >= 0; i--) begin
        send_bit(COM[i]);
        strobes += stb;
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL post_reset_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
      end
    n_tests++;
    if (strobes != 0 || act !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got strobes=%0d active=%b, expected 0 and 0", strobes, act);
    end
  endtask

  task automatic test_no_lock();
    logic [7:0] bd = 8'hBD;
    int seen = 0;
    assert_reset();
    release_reset();
    for (int k = 0; k < 10; k++)
      for (int i = 7; i >= 0; i--) begin
        send_bit(bd[i]);
        seen += act + stb;
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL nolock_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
      end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL nolock: got %0d cycles with active/strobe high, expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    assert_reset();
    release_reset();
    for (int k = 0; k < 60; k++) begin
      v = (k >= 2 && k < 6) || $urandom_range(3) == 0 ? COM : 8'($urandom);
      if (k < 2) v = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        send_bit(v[i]);
        n_tests++;
        if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
          n_fail++;
          $display("FAIL random_bit t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                   m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
        end
      end
    end
    assert_reset();
    release_reset();
    for (int j = 0; j < 400; j++) begin
      send_bit(1'($urandom));
      n_tests++;
      if ({act, vout, stb, dout} !== {m_act, m_valid, m_stb, m_data}) begin
        n_fail++;
        $display("FAIL random_stream t=%0d: got act=%b valid=%b strobe=%b data=%h, expected %b %b %b %h",
                 m_t, act, vout, stb, dout, m_act, m_valid, m_stb, m_data);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_data();
    test_com_break();
    test_slip();
    test_async_reset();
    test_no_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
